// File: rtl/oam_dma_arbiter.sv
// CPU/bus arbiter with NES-style OAM DMA: a write to the DMA register halts the CPU
// and copies one 256-byte page to the OAM data port, aligned to get/put cycles.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw_n,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_reg;
    logic [7:0] page_reg;
    logic [7:0] cnt_reg;
    logic [7:0] latch_reg;
    logic       parity_reg;
    logic       trigger;

    assign trigger = (state_reg == IDLE) && !cpu_rw_n && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            page_reg   <= 8'h00;
            cnt_reg    <= 8'h00;
            latch_reg  <= 8'h00;
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ~parity_reg;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        page_reg  <= cpu_wdata;
                        cnt_reg   <= 8'h00;
                        state_reg <= HALT;
                    end
                end
                // Current parity 1 means the next cycle is a get cycle, so READ can start there.
                HALT: state_reg <= parity_reg ? READ : ALIGN;
                ALIGN: state_reg <= READ;
                READ: begin
                    latch_reg <= bus_rdata;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    cnt_reg   <= cnt_reg + 8'd1;
                    state_reg <= (cnt_reg == 8'hFF) ? IDLE : READ;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_rw_n  = cpu_rw_n;
        case (state_reg)
            // Dummy cycles keep the CPU address but force a read so no CPU write leaks.
            HALT, ALIGN: bus_rw_n = 1'b1;
            READ: begin
                bus_addr = {page_reg, cnt_reg};
                bus_rw_n = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch_reg;
                bus_rw_n  = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_halt  = (state_reg != IDLE);
    assign dma_busy  = (state_reg != IDLE);
    assign cpu_rdata = bus_rdata;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: pass-through, even/odd aligned transfers,
// page $FF, ignored halted writes and a mid-transfer reset.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw_n;
    logic [7:0]  cpu_rdata;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw_n;
    logic [7:0]  bus_rdata;
    logic        dma_busy;

    int n_vec = 0;
    int n_err = 0;
    logic par;

    always #5 clk = ~clk;

    // Memory map model: every location reads back addr[7:0] ^ A5.
    assign bus_rdata = bus_addr[7:0] ^ 8'hA5;

    // Independent get/put phase model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par <= 1'b0;
        else        par <= ~par;
    end

    oam_dma_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw_n(cpu_rw_n),
        .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rw_n(bus_rw_n),
        .bus_rdata(bus_rdata), .dma_busy(dma_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_addr  = a;
        cpu_rw_n  = rw;
        cpu_wdata = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_read(input logic [15:0] a, input string tag);
        drive(a, 1'b1, 8'h00);
        #3;
        check(tag, {cpu_halt, dma_busy, bus_rw_n, bus_addr},
                   {1'b0, 1'b0, 1'b1, a});
        check({tag, "_rdata"}, cpu_rdata, a[7:0] ^ 8'hA5);
        next_cycle();
    endtask

    task automatic do_dma(input logic [7:0] pg, input bit odd, input bit hwrite,
                          input int abort_at);
        int halt_cnt;
        logic [7:0] b;
        halt_cnt = 0;
        if (par != odd) idle_read(16'h8000, "pre_align");
        // Trigger cycle: the write must still reach the bus.
        drive(16'h4014, 1'b0, pg);
        #3;
        check("trig_pass", {cpu_halt, bus_rw_n, bus_addr, bus_wdata},
                           {1'b0, 1'b0, 16'h4014, pg});
        next_cycle();
        for (int k = 0; k < (odd ? 2 : 1); k++) begin
            if (hwrite) drive(16'h4014, 1'b0, 8'h55);
            else        drive(16'h8000, 1'b1, 8'h00);
            #3;
            check(k == 0 ? "halt_cyc" : "align_cyc",
                  {cpu_halt, dma_busy, bus_rw_n, bus_addr},
                  {1'b1, 1'b1, 1'b1, cpu_addr});
            halt_cnt++;
            next_cycle();
        end
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            if (hwrite && i < 4) drive(16'h4014, 1'b0, 8'h55);
            else                 drive(16'h8000, 1'b1, 8'h00);
            #3;
            check("read_cyc", {cpu_halt, dma_busy, bus_rw_n, bus_addr, par},
                              {1'b1, 1'b1, 1'b1, pg, b, 1'b0});
            check("read_data", cpu_rdata, b ^ 8'hA5);
            halt_cnt++;
            if (i == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("abort_out", {cpu_halt, dma_busy, bus_rw_n, bus_addr},
                                   {1'b0, 1'b0, 1'b1, 16'h8000});
                next_cycle();
                rst_n = 1'b1;
                $display("dma page=%h aborted at byte %0d", pg, i);
                return;
            end
            next_cycle();
            drive(16'h8000, 1'b1, 8'h00);
            #3;
            check("write_cyc", {cpu_halt, dma_busy, bus_rw_n, bus_addr, bus_wdata, par},
                               {1'b1, 1'b1, 1'b0, 16'h2004, b ^ 8'hA5, 1'b1});
            halt_cnt++;
            next_cycle();
        end
        // Bus must return to the CPU right after the last OAM write.
        idle_read(16'h8000, "post_dma");
        check("halt_len", halt_cnt, odd ? 514 : 513);
        $display("dma page=%h odd=%0d hwrite=%0d halt_cycles=%0d", pg, odd, hwrite, halt_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16'h8000, 1'b1, 8'h00);
        #3;
        check("reset_out", {cpu_halt, dma_busy, bus_rw_n, bus_addr},
                           {1'b0, 1'b0, 1'b1, 16'h8000});
        next_cycle();
        rst_n = 1'b1;
        idle_read(16'h8000, "idle_8000");
        drive(16'h1234, 1'b0, 8'h9C);
        #3;
        check("idle_write", {cpu_halt, bus_rw_n, bus_addr, bus_wdata},
                            {1'b0, 1'b0, 16'h1234, 8'h9C});
        next_cycle();
        idle_read(16'hC0DE, "idle_c0de");

        do_dma(8'h02, 1'b0, 1'b0, -1);
        do_dma(8'h02, 1'b1, 1'b0, -1);
        do_dma(8'hFF, 1'b0, 1'b0, -1);
        do_dma(8'h03, 1'b1, 1'b1, -1);
        do_dma(8'h20, 1'b0, 1'b0, -1);
        do_dma(8'h04, 1'b1, 1'b0, 100);

        // After the aborted transfer nothing but CPU reads may appear.
        for (int i = 0; i < 600; i++) idle_read(16'h8000, "post_abort");
        $display("post-abort idle window complete");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Bus arbiter and sequencer sitting between `cpu_6502` and the system bus. It passes CPU accesses straight through. When the CPU writes the OAM DMA register ($4014), it halts the CPU's fetch and execute pipeline and takes ownership of the bus. It then copies 256 bytes from CPU page `XX00–XXFF` to the PPU OAM data port ($2004) with NES-accurate get/put cycle alignment, and returns the bus to the CPU.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU write address that triggers a transfer; written byte = source page.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every DMA write.

Ports:
- `clk`  in  1: single system clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cpu_addr`  in  16: CPU address.
- `cpu_wdata`  in  8: CPU write data.
- `cpu_rw_n`  in  1: CPU direction, 1 = read, 0 = write.
- `cpu_rdata`  out  8: read data to CPU; always equals `bus_rdata`.
- `cpu_halt`  out  1: stall request to CPU (freeze PC and pipeline registers); 1 whenever DMA owns the bus.
- `bus_addr`  out  16: address to memory map.
- `bus_wdata`  out  8: write data to memory map.
- `bus_rw_n`  out  1: bus direction, 1 = read.
- `bus_rdata`  in  8: read data from memory map.
- `dma_busy`  out  1: high from the first halt cycle through the last OAM write.

## Operation
- FSM states: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - `state`
  - `page[7:0]`
  - `cnt[7:0]`
  - `latch[7:0]`
  - `parity`: toggles every clock from reset; 0 = get cycle, 1 = put cycle.
- IDLE:
  - `bus_addr = cpu_addr`, `bus_wdata = cpu_wdata`, `bus_rw_n = cpu_rw_n`.
  - `cpu_halt = 0`, `dma_busy = 0`.
- Trigger: in IDLE with `cpu_rw_n = 0` and `cpu_addr = DMA_REG_ADDR`.
  - The write itself still passes through to the bus.
  - On that edge: `page <= cpu_wdata`, `cnt <= 0`, next state HALT.
- HALT: one dummy cycle.
  - Bus driven with `cpu_addr`, `bus_rw_n = 1` (read forced; no write leaks).
  - Next state is READ if the next cycle's `parity` = 0, else ALIGN.
- ALIGN: one dummy read cycle, same bus drive as HALT; next state READ.
- READ:
  - `bus_addr = {page, cnt}`, `bus_rw_n = 1`.
  - `latch <= bus_rdata` at end of cycle; next state WRITE.
- WRITE:
  - `bus_addr = OAM_DATA_ADDR`, `bus_wdata = latch`, `bus_rw_n = 0`.
  - `cnt <= cnt + 1` (8-bit, wraps).
  - If `cnt` was 255, next state IDLE; else READ.
- `cpu_halt = dma_busy = 1` in HALT, ALIGN, READ and WRITE.
- Address arithmetic: `{page, cnt}` only. No carry out of the page, so page $FF reads $FF00–$FFFF.
- CPU bus requests while halted are ignored, including a write to `DMA_REG_ADDR`; no retrigger.
- Any page value is legal, including $20 (PPU registers) and $40; reads are issued as-is.

## Timing
- Reset (async assert, any state, including mid-transfer):
  - `state = IDLE`, `cnt = 0`, `page = 0`, `latch = 0`, `parity = 0`.
  - `cpu_halt = 0`, `dma_busy = 0`.
  - Bus outputs follow the CPU pass-through.
  - A reset mid-transfer aborts it; the remaining bytes are not written.
- Bus and CPU outputs are combinational from `state` and registers: no added latency on pass-through.
- Trigger write at cycle T: `cpu_halt` rises at T+1.
- Transfer length in halt cycles:
  - 513 when the T+2 `parity` is 0: HALT, then 256 READ/WRITE pairs.
  - 514 otherwise: HALT, ALIGN, then 256 pairs.
- The first READ always falls on `parity` = 0; each WRITE falls on `parity` = 1.
- The final WRITE is the last cycle with `cpu_halt = 1`. The CPU owns the bus the following cycle.
- Each byte is read in cycle k and written in cycle k+1. `latch` is held stable through the WRITE.

## Test plan
- Reset then idle: CPU read of $8000 → `bus_addr = 8000`, `bus_rw_n = 1`, `cpu_rdata = bus_rdata`, `cpu_halt = 0`.
- Write $02 to $4014 with even alignment:
  - `cpu_halt` high for exactly 513 cycles.
  - 256 reads $0200–$02FF, each followed by a write of the same byte to $2004.
  - Memory model pattern `data = addr[7:0] ^ 8'hA5` is checked in OAM order 0–255.
- Same trigger shifted one cycle (odd alignment) → exactly 514 halt cycles, one ALIGN; first READ on `parity` = 0.
- Page $FF → last read at $FFFF; next CPU cycle is a pass-through and no $0000 access occurs.
- Assert `rst_n` low at byte 100 (mid-READ) → outputs drop to reset values immediately. After release, CPU pass-through resumes and no further $2004 writes occur.
- CPU presents a write to $4014 while halted → ignored; transfer count stays 256 and `page` is unchanged.
